// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter: round-robin arbiter whose grant stays locked to one requester until done.
// Define ARB_TIMEOUT_EN to add a hold counter and a timeout output that force-release long grants.
module rr_lock_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               done,
   output logic [NUM_REQ-1:0] grant,
   output logic               grant_valid,
`ifdef ARB_TIMEOUT_EN
   output logic [ID_W-1:0]    grant_id,
   output logic               timeout
`else
   output logic [ID_W-1:0]    grant_id
`endif
);

   if (NUM_REQ < 2 || NUM_REQ > 16 || ID_W != $clog2(NUM_REQ) || TIMEOUT < 1) begin : g_bad_params
      $error("rr_lock_arbiter: illegal parameter combination");
   end

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // state_q is kept as a named enum so checkers can probe the FSM directly.
   state_t              state_q, state_d;
   logic [ID_W-1:0]     ptr_q, ptr_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic                valid_q, valid_d;
   logic [ID_W-1:0]     pick_start;
   logic [ID_W:0]       pick_res;
   logic                release_now;
   logic                tmo_hit;

   // Returns {found, index} of the first set bit of r, searching start, start+1, ... with wrap.
   function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [ID_W-1:0]    start);
      logic [ID_W:0] res;
      int            idx;
      res = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(start) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (r[idx[ID_W-1:0]]) res = {1'b1, idx[ID_W-1:0]};
      end
      return res;
   endfunction

   function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id);
      return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
   endfunction

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tmo_hit = (state_q == BUSY) && (cnt_q == CNT_W'(TIMEOUT - 1));
   assign timeout = tmo_hit && !done;
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      grant_d     = grant_q;
      id_d        = id_q;
      valid_d     = valid_q;
      pick_start  = ptr_q;
      release_now = 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      // On release the search starts just past the holder, so the holder is tried last.
      if (state_q == BUSY) begin
         pick_start  = wrap_inc(id_q);
         release_now = done || tmo_hit;
      end
      pick_res = rr_pick(req, pick_start);

      case (state_q)
         IDLE: begin
            if (pick_res[ID_W]) begin
               state_d = BUSY;
               grant_d = NUM_REQ'(1) << pick_res[ID_W-1:0];
               id_d    = pick_res[ID_W-1:0];
               valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end else begin
               grant_d = '0;
               id_d    = '0;
               valid_d = 1'b0;
            end
         end
         BUSY: begin
            if (release_now) begin
               ptr_d = pick_start;
`ifdef ARB_TIMEOUT_EN
               cnt_d = '0;
`endif
               if (pick_res[ID_W]) begin
                  grant_d = NUM_REQ'(1) << pick_res[ID_W-1:0];
                  id_d    = pick_res[ID_W-1:0];
                  valid_d = 1'b1;
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
                  id_d    = '0;
                  valid_d = 1'b0;
               end
            end else begin
`ifdef ARB_TIMEOUT_EN
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            id_d    = '0;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         id_q    <= '0;
         valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         id_q    <= id_d;
         valid_q <= valid_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign grant       = grant_q;
   assign grant_valid = valid_q;
   assign grant_id    = id_q;

   a_onehot: assert property (@(posedge clk) disable iff (rst_n) $onehot0(grant_q));
   a_valid:  assert property (@(posedge clk) disable iff (rst_n) valid_q == (grant_q != '0));
   a_id:     assert property (@(posedge clk) disable iff (rst_n)
                              valid_q ? (grant_q[id_q] == 1'b1) : (id_q == '0));

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// tb_rr_lock_arbiter: directed and random stimulus against a queue/arithmetic model of the arbiter.
// Build with ARB_TIMEOUT_EN defined to also exercise the hold timeout.
module tb_rr_lock_arbiter;

   localparam int N       = 4;
   localparam int IDW     = 2;
   localparam int TIMEOUT = 16;
`ifdef ARB_TIMEOUT_EN
   localparam bit TMO_EN  = 1'b1;
`else
   localparam bit TMO_EN  = 1'b0;
`endif

   logic           clk;
   logic           rst_n;
   logic [N-1:0]   req;
   logic           done;
   logic [N-1:0]   grant;
   logic           grant_valid;
   logic [IDW-1:0] grant_id;
   logic           timeout;

   rr_lock_arbiter #(.NUM_REQ(N), .ID_W(IDW), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_valid (grant_valid),
`ifdef ARB_TIMEOUT_EN
      .grant_id    (grant_id),
      .timeout     (timeout)
`else
      .grant_id    (grant_id)
`endif
   );

`ifndef ARB_TIMEOUT_EN
   assign timeout = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard bookkeeping ----------------
   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Holder is an integer index; the grant vector is derived from it when compared.
   bit m_busy   = 1'b0;
   int m_holder = 0;
   int m_ptr    = 0;
   int m_cnt    = 0;

   function automatic int pick(input logic [N-1:0] r, input int start);
      for (int k = 0; k < N; k++) begin
         if (r[(start + k) % N]) return (start + k) % N;
      end
      return -1;
   endfunction

   always @(posedge clk) begin
      int w;
      bit rel;
      if (rst_n) begin
         m_busy = 1'b0; m_ptr = 0; m_cnt = 0; m_holder = 0;
      end else if (!m_busy) begin
         w = pick(req, m_ptr);
         if (w >= 0) begin
            m_busy = 1'b1; m_holder = w; m_cnt = 0;
         end
      end else begin
         rel = done || (TMO_EN && m_cnt == TIMEOUT - 1);
         if (rel) begin
            m_ptr = (m_holder + 1) % N;
            w = pick(req, m_ptr);
            m_cnt = 0;
            if (w >= 0) m_holder = w;
            else m_busy = 1'b0;
         end else begin
            m_cnt++;
         end
      end
   end

   // Compare process: DUT outputs against the model mid-cycle, every cycle after the first reset.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("m_grant", grant, m_busy ? (32'd1 << m_holder) : 32'd0);
         chk("m_valid", grant_valid, m_busy);
         chk("m_id", grant_id, m_busy ? m_holder : 0);
         if (TMO_EN)
            chk("m_timeout", timeout, m_busy && m_cnt == TIMEOUT - 1 && !done);
      end
   end

   // ---------------- driver ----------------
   // Inputs change 1 time unit after a rising edge and are sampled by the next one.
   task automatic tick(input logic [N-1:0] r, input logic d, input logic rs = 1'b0);
      req   = r;
      done  = d;
      rst_n = rs;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      tick('0, 1'b0, 1'b1);
      cmp_en = 1'b1;
   endtask

   logic [N-1:0] exp_q[$];
   logic [N-1:0] obs_q[$];
   logic [N-1:0] last_g;

   initial begin
      req = '0; done = 1'b0; rst_n = 1'b1;

      // reset state
      do_reset();
      chk("rst_grant", grant, 0);
      chk("rst_valid", grant_valid, 0);
      chk("rst_id", grant_id, 0);

      // all requesting, done every 3rd cycle: full rotation
      exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      last_g = '0;
      for (int c = 0; c < 12; c++) begin
         tick(4'b1111, (c % 3) == 2);
         if (grant_valid && grant != last_g) obs_q.push_back(grant);
         last_g = grant;
      end
      chk("rot_len", obs_q.size(), 5);
      for (int i = 0; i < 5; i++) chk("rot_seq", obs_q[i], exp_q[i]);
      tick('0, 1'b1);
      chk("rot_idle", grant_valid, 0);

      // lock holds while requests vanish
      tick(4'b1111, 1'b0);
      chk("lock_grant", grant, 4'b0010);
      for (int i = 0; i < 3; i++) begin
         tick(4'b0000, 1'b0);
         chk("lock_hold", grant, 4'b0010);
         chk("lock_valid", grant_valid, 1);
      end
      tick(4'b0000, 1'b1);
      chk("lock_rel_grant", grant, 0);
      chk("lock_rel_valid", grant_valid, 0);
      chk("lock_rel_id", grant_id, 0);

      // zero-bubble handoff 0001 -> 1000, then ptr wraps to 0
      do_reset();
      tick(4'b1001, 1'b0);
      chk("hand_first", grant, 4'b0001);
      tick(4'b1001, 1'b1);
      chk("hand_second", grant, 4'b1000);
      chk("hand_valid", grant_valid, 1);
      chk("hand_id", grant_id, 3);
      tick('0, 1'b1);
      tick(4'b1111, 1'b0);
      chk("wrap_ptr0", grant, 4'b0001);
      tick('0, 1'b1);

      // single requester re-granted on every done
      tick(4'b0100, 1'b0);
      chk("solo_first", grant, 4'b0100);
      for (int i = 0; i < 3; i++) begin
         tick(4'b0100, 1'b1);
         chk("solo_regrant", grant, 4'b0100);
         chk("solo_valid", grant_valid, 1);
      end
      tick('0, 1'b1);
      tick(4'b1001, 1'b0);
      chk("ptr3_grant", grant, 4'b1000);
      tick(4'b1001, 1'b1);
      chk("ptr_wrap_grant", grant, 4'b0001);
      tick('0, 1'b1);

      // reset while holding 1000
      tick(4'b1000, 1'b0);
      chk("pre_rst_grant", grant, 4'b1000);
      tick(4'b1000, 1'b0, 1'b1);
      chk("mid_rst_grant", grant, 0);
      chk("mid_rst_valid", grant_valid, 0);
      chk("mid_rst_id", grant_id, 0);
      tick(4'b1000, 1'b0);
      chk("post_rst_grant", grant, 4'b1000);
      chk("post_rst_id", grant_id, 3);
      tick('0, 1'b1);
      tick('0, 1'b1);
      chk("idle_done_ignored", grant_valid, 0);
      tick(4'b1010, 1'b0);
      chk("idle_ptr_kept", grant, 4'b0010);
      tick('0, 1'b1);

`ifdef ARB_TIMEOUT_EN
      // hold with no done: timeout on BUSY cycle 16, grant moves on
      do_reset();
      tick(4'b1111, 1'b0);
      chk("tmo_first", grant, 4'b0001);
      for (int k = 1; k <= TIMEOUT; k++) begin
         chk("tmo_pulse", timeout, k == TIMEOUT);
         tick(4'b1111, 1'b0);
      end
      chk("tmo_next", grant, 4'b0010);
      chk("tmo_clear", timeout, 0);
      tick('0, 1'b1);
`endif

      // randomized traffic checked by the compare process
      for (int i = 0; i < 3000; i++) begin
         tick(N'($urandom_range(0, 15)), $urandom_range(0, 9) == 0,
              $urandom_range(0, 299) == 0);
      end
      tick('0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/rr_lock_arbiter.md
RR_LOCK_ARBITER -- requirements
Module: rr_lock_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning the number of requesters; legal range 2..16.
REQ-002 SHALL have parameter ID_W, default 2, meaning the grant_id width; it SHALL equal ceil(log2(NUM_REQ)).
REQ-003 SHALL have parameter TIMEOUT, default 16, meaning the maximum cycles one grant may be held; it is used only under ARB_TIMEOUT_EN.
REQ-004 SHALL have port clk, input, width 1, meaning the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_n, input, width 1, meaning the synchronous active-high reset; reset is asserted when rst_n=1.
REQ-006 SHALL have port req, input, width NUM_REQ, meaning level request bit i from requester i.
REQ-007 SHALL have port done, input, width 1, meaning the current grant holder releases the grant this cycle.
REQ-008 SHALL have port grant, output, width NUM_REQ, meaning the registered one-hot grant, or all zero when no grant is held.
REQ-009 SHALL have port grant_valid, output, width 1, meaning grant is non-zero.
REQ-010 SHALL have port grant_id, output, width ID_W, meaning the binary index of the grant holder; it is 0 when grant_valid=0.

Function
REQ-011 SHALL implement a two-state FSM: IDLE (no grant held) and BUSY (grant locked to one requester).
REQ-012 SHALL hold a rotating priority pointer ptr of ID_W bits; the search order is ptr, ptr+1, ..., wrapping from NUM_REQ-1 to 0.
REQ-013 In IDLE with req≠0, SHALL select the first set req bit in search order, register grant/grant_id/grant_valid on the next edge, and enter BUSY (latency: 1 cycle from req sampled to grant visible).
REQ-014 In IDLE with req=0, SHALL hold all outputs at zero and leave ptr unchanged.
REQ-015 In BUSY, SHALL hold grant constant regardless of req changes, including the holder deasserting its req, until release.
REQ-016 In BUSY with done=1, SHALL set ptr to winner+1 mod NUM_REQ and re-arbitrate in the same cycle, with search starting at winner+1.
REQ-017 On that re-arbitration, if another winner exists, SHALL register the new grant on the next edge and stay in BUSY (zero bubble); otherwise SHALL clear the outputs and enter IDLE.
REQ-018 On re-arbitration, the releasing requester SHALL be eligible again only if no other requester is set (searched last).
REQ-019 SHALL ignore done while in IDLE.
REQ-020 SHALL keep grant strictly one-hot or zero on every cycle, and keep grant_id consistent with grant.
REQ-021 With NUM_REQ not a power of two, SHALL wrap ptr from NUM_REQ-1 to 0, never to an unused index.

Reset
REQ-022 When rst_n=1 at a rising edge, SHALL clear grant, grant_valid, grant_id and ptr to 0, set the FSM to IDLE, and clear the timeout counter.
REQ-023 Reset mid-BUSY SHALL drop the grant on that same edge; arbitration SHALL resume from ptr=0 on the first edge with rst_n=0.

Configuration
REQ-024 With macro ARB_TIMEOUT_EN defined, SHALL add output timeout (width 1) and a hold counter that clears on each new grant and increments each BUSY cycle.
REQ-025 With ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT-1 without done, SHALL force a release exactly as done=1 would (REQ-016/017) and pulse timeout high for 1 cycle.
REQ-026 With ARB_TIMEOUT_EN undefined, SHALL have no timeout port and no counter, and SHALL hold a grant indefinitely until done.

Verification (NUM_REQ=4)
REQ-027 SHALL check: reset, then req=4'b1111 held, done pulsed every 3rd cycle -> grant sequence 0001, 0010, 0100, 1000, 0001.
REQ-028 SHALL check: in BUSY with grant=0010, req changes to 4'b0000 -> grant stays 0010 until done, then 0000 and grant_valid=0 on the next edge.
REQ-029 SHALL check: req=4'b1001, ptr=0, done on the first grant -> grants 0001 then 1000 with no idle cycle between them.
REQ-030 SHALL check: only req[2] set, repeated done -> grant 0100 re-granted each time; ptr wraps 3->0 correctly.
REQ-031 SHALL check: rst_n=1 asserted while grant=1000 -> all outputs 0 on that edge; after release, req=4'b1000 -> grant 1000 one cycle later.
REQ-032 SHALL check, with ARB_TIMEOUT_EN and TIMEOUT=16: grant 0001 held with no done -> timeout pulses on BUSY cycle 16 and the grant moves to the next requester.
